// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Holds the FSM state encoding, the {row,col} -> hex key map, the clear key
// code used by the optional KEYPAD_CLEAR_EN build, and a priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Indexed by {row[1:0], col[1:0]}; index 15 is the leftmost entry.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [3:0] CLEAR_CODE = 4'hE;

  // Index of the lowest zero bit; lowest index wins when several are low.
  // Also recovers the driven row from the one-hot-low row vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    low_index = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) low_index = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad-side bus: row drive and column sense toward the matrix, decoded key
// and entry register toward the display. master = scanner, slave = far side.
interface keypad_if;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] entry;

  modport master (
    output rows, key_code, key_valid, entry,
    input  cols
  );

  modport slave (
    input  rows, key_code, key_valid, entry,
    output cols
  );
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad columns.
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Resample the columns twice; reset to the pulled-up idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      // NOTE: flops always use non-blocking assignments so both stages load
      // their pre-edge values; blocking here would collapse the two stages.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a low row every scan tick, debounces a
// press and a release over DEBOUNCE_TICKS ticks, decodes the hex code and
// shifts accepted digits into a 4-digit entry register.
// Optional build macro KEYPAD_CLEAR_EN: key code E clears the entry register
// instead of shifting in.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 15,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_TICKS - 1);

  logic [SCAN_DIV_W-1:0] div_q;
  logic                  tick;
  logic [3:0]            cs;

  state_e      state_q,     state_d;
  logic [3:0]  rows_q,      rows_d;
  logic [1:0]  r_q,         r_d;
  logic [1:0]  c_q,         c_d;
  logic [3:0]  deb_cnt_q,   deb_cnt_d;
  logic [3:0]  rel_cnt_q,   rel_cnt_d;
  logic [3:0]  key_code_q,  key_code_d;
  logic        key_valid_q, key_valid_d;
  logic [15:0] entry_q,     entry_d;

  logic        accept;
  logic [3:0]  acc_idx;
  logic [3:0]  new_code;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.cols),
    .q_o (cs)
  );

  // Free-running scan divider; tick marks the end of each row dwell.
  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_q + 1'b1;
  end

  assign tick = &div_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      rows_q      <= 4'b1110;
      r_q         <= 2'd0;
      c_q         <= 2'd0;
      deb_cnt_q   <= 4'd0;
      rel_cnt_q   <= 4'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      entry_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      r_q         <= r_d;
      c_q         <= c_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      entry_q     <= entry_d;
    end
  end

  // Next-state: scan rotation, press/release debounce, key decode and shift.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    rows_d      = rows_q;
    r_d         = r_q;
    c_d         = c_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    entry_d     = entry_q;
    accept      = 1'b0;
    acc_idx     = {r_q, c_q};
    new_code    = 4'h0;

    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (cs == 4'hF) begin
            rows_d = {rows_q[2:0], rows_q[3]};
          end else begin
            // Freeze on the driven row; the detect tick is the first low tick.
            r_d       = low_index(rows_q);
            c_d       = low_index(cs);
            deb_cnt_d = 4'd0;
            state_d   = DEBOUNCE;
            acc_idx   = {low_index(rows_q), low_index(cs)};
            if (DEB_LAST == 4'd0) accept = 1'b1;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (!cs[c_q]) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if (deb_cnt_d == DEB_LAST) accept = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end

      HELD: begin
        // Any low column restarts the release count, so a second key pressed
        // while the first is held is absorbed until everything is released.
        if (tick) begin
          if (cs == 4'hF) begin
            rel_cnt_d = rel_cnt_q + 4'd1;
            if (rel_cnt_d >= DEB_LAST) state_d = SCAN;
          end else begin
            rel_cnt_d = 4'd0;
          end
        end
      end

      default: state_d = SCAN;
    endcase

    if (accept) begin
      new_code    = KEY_MAP[acc_idx];
      key_code_d  = new_code;
      key_valid_d = 1'b1;
      rel_cnt_d   = 4'd0;
      state_d     = HELD;
`ifdef KEYPAD_CLEAR_EN
      if (new_code == CLEAR_CODE) entry_d = 16'h0000;
      else                        entry_d = {entry_q[11:0], new_code};
`else
      entry_d = {entry_q[11:0], new_code};
`endif
    end
  end

  assign kp.rows      = rows_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.entry     = entry_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart of the multiplexed 4-digit 7-segment display driver. It scans a 4x4 matrix keypad by driving one row low at a time and reading the active-low columns. Each keypress is debounced and decoded into a 4-bit hex code. Accepted digits are shifted into a 16-bit, 4-digit entry register that feeds the display driver's data nibbles.

Parameters:
SCAN_DIV_W, 15, width of the free-running scan divider; one scan tick every 2^SCAN_DIV_W clocks.
DEBOUNCE_TICKS, 4, number of consecutive stable ticks needed to accept a press or a release (range 1..15).

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous reset, active-high.
rows  output  4  row drive, active-low, one-hot-low; the driven row is the zero bit.
cols  input  4  column sense, active-low (pulled up externally), asynchronous.
key_code  output  4  hex code of the last accepted key.
key_valid  output  1  one-clk pulse when key_code is updated.
entry  output  16  last four accepted digits; entry[15:12] is the oldest, entry[3:0] the newest.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all state updates on posedge clk.
- Reset values: rows=4'b1110, key_code=0, key_valid=0, entry=0, divider=0, all counters=0, state=SCAN.
- A reset asserted mid-debounce or mid-hold aborts the operation with no key_valid pulse.
- cols pass through a 2-flop synchronizer; all decisions use the synchronized value cs.
- Divider: increments every clk and wraps. tick is a one-clk pulse when the divider is all-ones.
- Sampling: cs is sampled only on tick cycles, at the end of the current row's dwell.
- Column priority: if several columns are low, the lowest index wins.
- SCAN state:
  - On tick with cs==4'hF, rotate the row: rows <= {rows[2:0],rows[3]}.
  - On tick with cs!=4'hF, latch row index r and column c, clear deb_cnt, go to DEBOUNCE, and keep rows frozen.
- DEBOUNCE state:
  - On tick with cs[c]==0, deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_TICKS-1 on such a tick: key_code <= MAP[r][c], key_valid=1 for that clk, clear rel_cnt, go to HELD.
  - On tick with cs[c]==1, go to SCAN with no pulse; rotation resumes on the next tick.
- HELD state:
  - rows stay frozen; no repeat pulses while the key is held.
  - On tick with cs==4'hF, rel_cnt++; on tick with any column low, rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_TICKS-1 on an all-high tick, go to SCAN.
- Press latency: key_valid asserts on the DEBOUNCE_TICKS-th consecutive low tick, counting the detect tick as the first.
- Key map MAP[row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Entry update: on the same edge that sets key_valid, entry <= {entry[11:0], key_code_new}. The oldest digit is dropped.
- Pressing a second key while one is held is ignored until full release.

Optional Feature:
KEYPAD_CLEAR_EN
- Defined: an accepted key code 4'hE clears entry to 16'h0000 instead of shifting; key_valid and key_code still update.
- Undefined: 4'hE shifts in like any other digit.

Decomposition:
- Package keypad_pkg holds:
  - state encoding SCAN/DEBOUNCE/HELD (2-bit typedef);
  - KEY_MAP constant, a 16-entry array of 4-bit codes indexed by {row,col};
  - CLEAR_CODE = 4'hE.
- One sub-module, keypad_sync: 2-flop synchronizer, 4 bits wide.
- The FSM, divider and entry shifter stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV_W=2 and DEBOUNCE_TICKS=3.
1. Reset: assert rst for 3 clks with cols=F, then release -> rows=1110, entry=0000, key_valid=0. rows advance to 1101 after 4 clks, then 1011.
2. Clean press: hold cols=1101 while rows=1011 (row2, col1) for 5 ticks -> exactly one key_valid pulse on the 3rd tick, key_code=8, entry=0008. No further pulse while held. After cols=F for 3 ticks, scanning resumes.
3. Bounce: cols low for 1 tick, high for 1 tick, low for 1 tick during DEBOUNCE -> returns to SCAN with no key_valid pulse.
4. Sequence 1,5,0,1 with full releases between keys -> entry=1501. A fifth key A gives entry=501A.
5. Simultaneous columns: cols=1100 on row0 -> key_code=1 (column 0 wins). Assert rst mid-debounce -> no pulse, all outputs at reset values.
6. Clear key: with entry=1234, press row3/col0 -> with KEYPAD_CLEAR_EN defined, entry=0000 and key_code=E; without it, entry=234E.
